// File: rtl/freq_counter_pkg.sv
// Shared definitions for the frequency-counter family: default widths and
// the gate controller state encoding.
package freq_counter_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_GATE_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_GATE = 2'd2
    } gate_state_t;

endpackage

// File: rtl/gray2bin.sv
// Registered gray-to-binary converter. The binary value of the gray word
// sampled on one rising edge is presented until the next edge.
module gray2bin #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] gray_i,
    output logic [DATA_WIDTH-1:0] bin_o
);

    logic [DATA_WIDTH-1:0] w_bin;
    logic [DATA_WIDTH-1:0] r_bin;

    // Each binary bit is the XOR of all gray bits at or above it.
    always_comb begin
        w_bin = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_bin[i] = ^(gray_i >> i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin <= '0;
        end else begin
            r_bin <= w_bin;
        end
    end

    assign bin_o = r_bin;

endmodule

// File: rtl/freq_gate_controller.sv
// Gated event counter: measures how far a gray-coded event count advances
// over a programmable number of clk cycles, once or back-to-back.
// Result handshake: freq_o is transferred on any rising edge where freq_valid_o
// and freq_ready_i are both high; valid stays high until that transfer.
module freq_gate_controller
    import freq_counter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int GATE_WIDTH = DEFAULT_GATE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] gray_count_i,
    input  logic [GATE_WIDTH-1:0] gate_cycles_i,
    input  logic                  start_i,
    input  logic                  continuous_i,
    input  logic                  stop_i,
    output logic                  busy_o,
    output logic [DATA_WIDTH-1:0] freq_o,
    output logic                  freq_valid_o,
    input  logic                  freq_ready_i,
    output logic                  overrun_o,
    output logic [1:0]            state_o
);

    gate_state_t           r_state;
    gate_state_t           w_next_state;
    logic                  w_accept;
    logic                  w_arm;
    logic                  w_end;
    logic                  w_tick;

    logic [DATA_WIDTH-1:0] w_bin;
    logic [GATE_WIDTH-1:0] r_gate_cycles;
    logic                  r_cont;
    logic [GATE_WIDTH-1:0] r_down;
    logic [DATA_WIDTH-1:0] r_start_val;
    logic [DATA_WIDTH-1:0] r_end_val;
    logic [DATA_WIDTH-1:0] r_win_start;
    logic                  r_load;
    logic [DATA_WIDTH-1:0] r_freq;
    logic                  r_valid;
    logic                  r_overrun;

    gray2bin #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_gray2bin (
        .clk    (clk),
        .rst    (rst),
        .gray_i (gray_count_i),
        .bin_o  (w_bin)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_arm        = 1'b0;
        w_end        = 1'b0;
        w_tick       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i && !stop_i) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_ARM;
                end
            end
            ST_ARM: begin
                if (stop_i) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_arm        = 1'b1;
                    w_next_state = ST_GATE;
                end
            end
            ST_GATE: begin
                if (stop_i) begin
                    w_next_state = ST_IDLE;
                end else if (r_down == '0) begin
                    w_end = 1'b1;
                    if (!r_cont) begin
                        w_next_state = ST_IDLE;
                    end
                end else begin
                    w_tick = 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gate_cycles <= '0;
            r_cont        <= 1'b0;
            r_down        <= '0;
            r_start_val   <= '0;
            r_end_val     <= '0;
            r_win_start   <= '0;
            r_load        <= 1'b0;
            r_freq        <= '0;
            r_valid       <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_gate_cycles <= (gate_cycles_i == '0) ? GATE_WIDTH'(1) : gate_cycles_i;
                r_cont        <= continuous_i;
            end

            if (w_arm) begin
                r_start_val <= w_bin;
                r_down      <= r_gate_cycles - GATE_WIDTH'(1);
            end else if (w_end) begin
                r_end_val   <= w_bin;
                r_win_start <= r_start_val;
                // The closing snapshot opens the next window with no dead cycle.
                if (r_cont) begin
                    r_start_val <= w_bin;
                    r_down      <= r_gate_cycles - GATE_WIDTH'(1);
                end
            end else if (w_tick) begin
                r_down <= r_down - GATE_WIDTH'(1);
            end

            r_load <= w_end;

            if (r_load) begin
                r_freq  <= r_end_val - r_win_start;
                r_valid <= 1'b1;
                if (r_valid && !freq_ready_i) begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && freq_ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign busy_o       = (r_state != ST_IDLE);
    assign freq_o       = r_freq;
    assign freq_valid_o = r_valid;
    assign overrun_o    = r_overrun;
    assign state_o      = r_state;

endmodule

// File: tb/tb_freq_gate_controller.sv
// Directed bench for freq_gate_controller: a table of single-shot windows
// followed by continuous, overrun, abort and mid-window reset sequences.
module tb_freq_gate_controller;

    localparam int DW = 32;
    localparam int GW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] gray_count_i;
    logic [GW-1:0] gate_cycles_i;
    logic          start_i;
    logic          continuous_i;
    logic          stop_i;
    logic          busy_o;
    logic [DW-1:0] freq_o;
    logic          freq_valid_o;
    logic          freq_ready_i;
    logic          overrun_o;
    logic [1:0]    state_o;

    logic [DW-1:0] ev_cnt;
    logic          load_req;
    logic [DW-1:0] load_val;
    int            cyc = 0;

    int n_checks = 0;
    int n_pass   = 0;
    logic [DW-1:0] exp_q[$];

    freq_gate_controller #(
        .DATA_WIDTH(DW),
        .GATE_WIDTH(GW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .gray_count_i (gray_count_i),
        .gate_cycles_i(gate_cycles_i),
        .start_i      (start_i),
        .continuous_i (continuous_i),
        .stop_i       (stop_i),
        .busy_o       (busy_o),
        .freq_o       (freq_o),
        .freq_valid_o (freq_valid_o),
        .freq_ready_i (freq_ready_i),
        .overrun_o    (overrun_o),
        .state_o      (state_o)
    );

    // clock / event source
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (load_req) ev_cnt <= load_val;
        else          ev_cnt <= ev_cnt + 1;
    end

    assign gray_count_i = ev_cnt ^ (ev_cnt >> 1);

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    // checking helpers
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_counter(input logic [DW-1:0] val);
        load_req = 1'b1;
        load_val = val;
        @(negedge clk);
        load_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_window(input logic [GW-1:0] gate, input logic cont);
        start_i       = 1'b1;
        gate_cycles_i = gate;
        continuous_i  = cont;
        @(negedge clk);
        start_i       = 1'b0;
        // latched values must not follow the inputs while busy
        gate_cycles_i = 32'd999;
        continuous_i  = ~cont;
    endtask

    task automatic wait_valid(input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (freq_valid_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({name, "_valid_seen"}, 64'(ok), 64'd1);
    endtask

    typedef struct {
        logic [DW-1:0] base;
        logic [GW-1:0] gate;
        logic [DW-1:0] exp_freq;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int prev_cyc;

        vecs[0] = '{base: 32'h0000_0000, gate: 32'd100, exp_freq: 32'd100};
        vecs[1] = '{base: 32'hFFFF_FFC0, gate: 32'd128, exp_freq: 32'd128};
        vecs[2] = '{base: 32'h1234_5678, gate: 32'd1,   exp_freq: 32'd1};
        vecs[3] = '{base: 32'h0000_0010, gate: 32'd0,   exp_freq: 32'd1};
        vecs[4] = '{base: 32'hFFFF_FFFF, gate: 32'd7,   exp_freq: 32'd7};
        vecs[5] = '{base: 32'h8000_0000, gate: 32'd33,  exp_freq: 32'd33};

        rst           = 1'b1;
        load_req      = 1'b1;
        load_val      = '0;
        gate_cycles_i = '0;
        start_i       = 1'b0;
        continuous_i  = 1'b0;
        stop_i        = 1'b0;
        freq_ready_i  = 1'b0;
        tick(3);
        check("reset_busy",    64'(busy_o),       64'd0);
        check("reset_freq",    64'(freq_o),       64'd0);
        check("reset_valid",   64'(freq_valid_o), 64'd0);
        check("reset_overrun", 64'(overrun_o),    64'd0);
        check("reset_state",   64'(state_o),      64'd0);
        rst      = 1'b0;
        load_req = 1'b0;
        tick(2);

        // single-shot windows
        for (int v = 0; v < 6; v++) begin
            load_counter(vecs[v].base);
            start_window(vecs[v].gate, 1'b0);
            check($sformatf("vec%0d_busy_running", v), 64'(busy_o), 64'd1);
            wait_valid(int'(vecs[v].gate) + 10, $sformatf("vec%0d", v));
            check($sformatf("vec%0d_freq", v), 64'(freq_o), 64'(vecs[v].exp_freq));
            check($sformatf("vec%0d_busy_done", v), 64'(busy_o), 64'd0);
            freq_ready_i = 1'b1;
            @(negedge clk);
            freq_ready_i = 1'b0;
            check($sformatf("vec%0d_valid_cleared", v), 64'(freq_valid_o), 64'd0);
            tick(2);
        end

        // continuous, gate 10, always ready: results exactly 10 cycles apart
        freq_ready_i = 1'b1;
        start_window(32'd10, 1'b1);
        prev_cyc = 0;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(32'd10);
            wait_valid(30, $sformatf("cont10_r%0d", k));
            check($sformatf("cont10_freq%0d", k), 64'(freq_o), 64'(exp_q.pop_front()));
            if (k > 0) check($sformatf("cont10_gap%0d", k), 64'(cyc - prev_cyc), 64'd10);
            prev_cyc = cyc;
            @(negedge clk);
        end
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
        check("cont10_stop_busy", 64'(busy_o),    64'd0);
        check("cont10_overrun",   64'(overrun_o), 64'd0);
        tick(3);
        check("cont10_drained", 64'(freq_valid_o), 64'd0);

        // continuous, gate 1, always ready: load and handshake coincide
        start_window(32'd1, 1'b1);
        wait_valid(10, "cont1");
        for (int k = 0; k < 8; k++) begin
            check($sformatf("cont1_valid%0d", k),   64'(freq_valid_o), 64'd1);
            check($sformatf("cont1_freq%0d", k),    64'(freq_o),       64'd1);
            check($sformatf("cont1_overrun%0d", k), 64'(overrun_o),    64'd0);
            @(negedge clk);
        end
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
        tick(3);
        check("cont1_drained", 64'(freq_valid_o), 64'd0);
        freq_ready_i = 1'b0;

        // continuous, gate 10, consumer stalled: second result overruns
        start_window(32'd10, 1'b1);
        wait_valid(30, "ovr_first");
        check("ovr_first_freq",    64'(freq_o),    64'd10);
        check("ovr_first_overrun", 64'(overrun_o), 64'd0);
        tick(10);
        check("ovr_second_overrun", 64'(overrun_o),    64'd1);
        check("ovr_second_valid",   64'(freq_valid_o), 64'd1);
        check("ovr_second_freq",    64'(freq_o),       64'd10);
        stop_i       = 1'b1;
        freq_ready_i = 1'b1;
        @(negedge clk);
        stop_i       = 1'b0;
        freq_ready_i = 1'b0;
        check("ovr_handshake_valid", 64'(freq_valid_o), 64'd0);
        check("ovr_stop_busy",       64'(busy_o),       64'd0);
        check("ovr_sticky",          64'(overrun_o),    64'd1);

        // abort at gate cycle 5, then a zero-length request clamps to 1
        start_window(32'd20, 1'b0);
        tick(6);
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
        check("abort_busy", 64'(busy_o), 64'd0);
        tick(30);
        check("abort_no_result", 64'(freq_valid_o), 64'd0);
        check("abort_freq_kept", 64'(freq_o),       64'd10);
        start_window(32'd0, 1'b0);
        wait_valid(10, "clamp");
        check("clamp_freq", 64'(freq_o), 64'd1);
        freq_ready_i = 1'b1;
        @(negedge clk);
        freq_ready_i = 1'b0;

        // start then ignored start/stop-priority in IDLE
        start_i = 1'b1;
        stop_i  = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        stop_i  = 1'b0;
        check("stop_beats_start", 64'(busy_o), 64'd0);

        // reset in the middle of a window
        start_window(32'd20, 1'b0);
        tick(8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy",    64'(busy_o),       64'd0);
        check("rst_freq",    64'(freq_o),       64'd0);
        check("rst_valid",   64'(freq_valid_o), 64'd0);
        check("rst_overrun", 64'(overrun_o),    64'd0);
        check("rst_state",   64'(state_o),      64'd0);
        tick(1);
        start_window(32'd20, 1'b0);
        wait_valid(40, "post_rst");
        check("post_rst_freq", 64'(freq_o), 64'd20);
        check("post_rst_busy", 64'(busy_o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/freq_gate_controller.md
FREQ_GATE_CONTROLLER -- requirements
Module: freq_gate_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the gray count and of the result.
REQ-002 SHALL have parameter GATE_WIDTH, default 32, width of the gate-length configuration.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port gray_count_i  input  DATA_WIDTH  gray-coded event count, already synchronized into clk.
REQ-006 SHALL have port gate_cycles_i  input  GATE_WIDTH  gate length in clk cycles, sampled at start.
REQ-007 SHALL have port start_i  input  1  one-cycle pulse that begins a measurement.
REQ-008 SHALL have port continuous_i  input  1  when 1, windows repeat back-to-back; sampled at start.
REQ-009 SHALL have port stop_i  input  1  abort request.
REQ-010 SHALL have port busy_o  output  1  high in ARM and GATE.
REQ-011 SHALL have port freq_o  output  DATA_WIDTH  events counted in the last completed window.
REQ-012 SHALL have port freq_valid_o  output  1  freq_o holds an unconsumed result.
REQ-013 SHALL have port freq_ready_i  input  1  consumer accepts freq_o when valid and ready are both high.
REQ-014 SHALL have port overrun_o  output  1  sticky; an unconsumed result was overwritten.

Function
REQ-015 SHALL convert gray_count_i to binary through one register stage, so the binary value of the input sampled at cycle t is available at t+1.
REQ-016 SHALL implement states IDLE, ARM and GATE.
REQ-017 IDLE: start_i=1 and stop_i=0 SHALL latch gate_cycles_i (0 clamped to 1) and continuous_i, then go to ARM; otherwise stay in IDLE.
REQ-018 ARM: SHALL snapshot the binary count as start_val, load the gate down-counter with gate_cycles-1, and go to GATE in one cycle.
REQ-019 GATE: SHALL decrement the down-counter every cycle; at 0 it SHALL snapshot end_val, exactly gate_cycles clk cycles after start_val.
REQ-020 At end of window SHALL compute result = end_val - start_val modulo 2^DATA_WIDTH, so counter wrap-around gives the correct count.
REQ-021 At end of window SHALL go to IDLE if continuous=0; if continuous=1 SHALL use end_val as the next start_val, reload the down-counter and stay in GATE, with zero dead cycles.
REQ-022 SHALL register result into freq_o and assert freq_valid_o on the cycle after the end snapshot.
REQ-023 SHALL clear freq_valid_o on handshake (valid and ready) unless a new result loads in the same cycle, in which case valid stays 1 and overrun_o is not set.
REQ-024 SHALL overwrite freq_o and set overrun_o when a new result loads while valid=1 and ready=0; overrun_o SHALL clear only on rst.
REQ-025 stop_i in ARM or GATE SHALL return to IDLE on the next cycle without producing a result; a result already in freq_o SHALL be kept.
REQ-026 SHALL ignore start_i while busy; if start_i and stop_i are both high in IDLE, stop SHALL win.
REQ-027 SHALL not change latched gate_cycles or continuous while busy.

Reset
REQ-028 On rst SHALL go to IDLE and clear busy_o, freq_o, freq_valid_o, overrun_o, the down-counter and both snapshots to 0.
REQ-029 rst asserted mid-window SHALL discard the window; the first start after reset SHALL behave identically to the first start after power-up.

Structure
REQ-030 SHALL place the state enum (IDLE, ARM, GATE) and the default widths in shared package freq_counter_pkg.
REQ-031 SHALL implement the registered gray-to-binary conversion as sub-module gray2bin (parameter DATA_WIDTH), reusable by other frequency-counter blocks.

Verification
REQ-032 Gray input from a binary counter incrementing every cycle from 0; gate_cycles=100, single start -> one result, freq_o=100, then busy_o=0.
REQ-033 Counter starting at 0xFFFFFFC0, +1 per cycle, gate_cycles=128 -> freq_o=128 across the wrap.
REQ-034 continuous=1, gate_cycles=10, ready held 1 -> a result every 10 cycles, each freq_o=10, no gaps, overrun_o=0.
REQ-035 continuous=1, gate_cycles=10, ready=0 for 25 cycles -> overrun_o=1 after the 2nd result; freq_o=10 still valid; first handshake clears valid.
REQ-036 stop_i pulsed at gate cycle 5, then start with gate_cycles=0 -> no result from the aborted window; next window uses 1 cycle and freq_o=1.
REQ-037 rst pulsed mid-GATE -> all outputs 0 next cycle; a following start with gate_cycles=20 gives freq_o=20.
